// File: rtl/alu_cmd_driver.sv
// Drives registered operands onto a combinational ALU, samples the result after a
// settle time and buffers it in a response FIFO. Optional macro: ALU_DRV_CHAIN_EN.
module alu_cmd_driver #(
    parameter int DATA_W    = 32,
    parameter int OP_W      = 4,
    parameter int SETTLE    = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // Both handshakes transfer on the rising edge where valid && ready; ready never
    // looks at valid, and a presented response holds its data until it is taken.
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [OP_W-1:0]   cmd_op,
`ifdef ALU_DRV_CHAIN_EN
    input  logic              cmd_chain,
`endif
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [OP_W-1:0]   rsp_op,
    output logic              busy,
    output logic              dbgState
);

    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} stateT;

    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT   = CNT_W'(RSP_DEPTH);
    localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE - 1);

    stateT             state;
    logic [3:0]        settleCnt;
    logic [DATA_W-1:0] dataMem [RSP_DEPTH];
    logic [OP_W-1:0]   opMem   [RSP_DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [CNT_W-1:0]  fifoCount;
    logic              accept;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] nextA;

    // Gated by rst_n so the host sees no readiness while reset is held.
    assign cmd_ready = rst_n && (state == IDLE) && (fifoCount < DEPTH_CNT);
    assign accept    = cmd_valid && cmd_ready;
    assign push      = (state == EXEC) && (settleCnt == 4'd0);
    assign pop       = rsp_valid && rsp_ready;
    assign busy      = (state == EXEC);
    assign dbgState  = state;
    assign rsp_valid = (fifoCount != '0);
    assign rsp_data  = dataMem[rdPtr];
    assign rsp_op    = opMem[rdPtr];

`ifdef ALU_DRV_CHAIN_EN
    logic [DATA_W-1:0] lastResult;

    assign nextA = cmd_chain ? lastResult : cmd_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastResult <= '0;
        end else if (push) begin
            lastResult <= alu_result;
        end
    end
`else
    assign nextA = cmd_a;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            settleCnt <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a     <= nextA;
                        alu_b     <= cmd_b;
                        alu_op    <= cmd_op;
                        settleCnt <= SETTLE_INIT;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    if (settleCnt == 4'd0) begin
                        state <= IDLE;
                    end else begin
                        settleCnt <= settleCnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Admission control guarantees a push never meets a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                dataMem[i] <= '0;
                opMem[i]   <= '0;
            end
        end else begin
            if (push) begin
                dataMem[wrPtr] <= alu_result;
                opMem[wrPtr]   <= alu_op;
                wrPtr          <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifoCount <= fifoCount + 1'b1;
                2'b01:   fifoCount <= fifoCount - 1'b1;
                default: fifoCount <= fifoCount;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver: adder ALU model, scoreboard of expected responses,
// one instance with SETTLE=1 and one with SETTLE=3.
module tb_alu_cmd_driver;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;
  localparam int W      = DATA_W + OP_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT with SETTLE=1 ----------------
  logic              cmdValid = 1'b0;
  logic              cmdReady;
  logic [DATA_W-1:0] cmdA = '0;
  logic [DATA_W-1:0] cmdB = '0;
  logic [OP_W-1:0]   cmdOp = '0;
  logic              cmdChain = 1'b0;
  logic [DATA_W-1:0] aluA, aluB, aluResult;
  logic [OP_W-1:0]   aluOp;
  logic              rspValid;
  logic              rspReady = 1'b0;
  logic [DATA_W-1:0] rspData;
  logic [OP_W-1:0]   rspOp;
  logic              busy, dbgState;

  assign aluResult = aluA + aluB;

  alu_cmd_driver #(.DATA_W(DATA_W), .OP_W(OP_W), .SETTLE(1), .RSP_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmdValid), .cmd_ready(cmdReady),
    .cmd_a(cmdA), .cmd_b(cmdB), .cmd_op(cmdOp),
`ifdef ALU_DRV_CHAIN_EN
    .cmd_chain(cmdChain),
`endif
    .alu_a(aluA), .alu_b(aluB), .alu_op(aluOp), .alu_result(aluResult),
    .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_data(rspData), .rsp_op(rspOp),
    .busy(busy), .dbgState(dbgState)
  );

  // ---------------- DUT with SETTLE=3 ----------------
  logic              c3Valid = 1'b0;
  logic              c3Ready;
  logic [DATA_W-1:0] c3A = '0;
  logic [DATA_W-1:0] c3B = '0;
  logic [OP_W-1:0]   c3Op = '0;
  logic              c3Chain = 1'b0;
  logic [DATA_W-1:0] alu3A, alu3B, alu3Result;
  logic [OP_W-1:0]   alu3Op;
  logic              rsp3Valid;
  logic              rsp3Ready = 1'b1;
  logic [DATA_W-1:0] rsp3Data;
  logic [OP_W-1:0]   rsp3Op;
  logic              busy3, dbg3State;

  assign alu3Result = alu3A + alu3B;

  alu_cmd_driver #(.DATA_W(DATA_W), .OP_W(OP_W), .SETTLE(3), .RSP_DEPTH(4)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(c3Valid), .cmd_ready(c3Ready),
    .cmd_a(c3A), .cmd_b(c3B), .cmd_op(c3Op),
`ifdef ALU_DRV_CHAIN_EN
    .cmd_chain(c3Chain),
`endif
    .alu_a(alu3A), .alu_b(alu3B), .alu_op(alu3Op), .alu_result(alu3Result),
    .rsp_valid(rsp3Valid), .rsp_ready(rsp3Ready), .rsp_data(rsp3Data), .rsp_op(rsp3Op),
    .busy(busy3), .dbgState(dbg3State)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0]      exp_q[$];
  logic [DATA_W-1:0] mdlLast = '0;
  int                nChecks = 0;
  int                nFail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nChecks++;
    assert (obs === expv) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // One clock: record the transfers that happen on the coming edge, then step past it.
  task automatic tick();
    logic [DATA_W-1:0] aEff;
    logic [W-1:0]      expv;
    if (cmdValid && cmdReady) begin
      aEff = cmdA;
`ifdef ALU_DRV_CHAIN_EN
      if (cmdChain) aEff = mdlLast;
`endif
      mdlLast = aEff + cmdB;
      exp_q.push_back({mdlLast, cmdOp});
    end
    if (rspValid && rspReady) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_rsp", 64'(rspValid), 64'(0));
      end else begin
        expv = exp_q.pop_front();
        check("sb_rsp", 64'({rspData, rspOp}), 64'(expv));
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic sendCmd(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input logic [OP_W-1:0] op, input logic chain);
    bit done = 0;
    cmdValid = 1'b1;
    cmdA     = a;
    cmdB     = b;
    cmdOp    = op;
    cmdChain = chain;
    for (int i = 0; i < 20 && !done; i++) begin
      if (cmdReady) done = 1;
      tick();
    end
    if (!done) check("cmd_accept_timeout", 64'(0), 64'(1));
    cmdValid = 1'b0;
    cmdChain = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [DATA_W-1:0] sumB;
    int guard;

    // Reset state
    tick();
    tick();
    check("rst_cmd_ready", 64'(cmdReady), 64'(0));
    check("rst_rsp_valid", 64'(rspValid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_alu_a", 64'(aluA), 64'(0));
    check("rst_rsp_data", 64'(rspData), 64'(0));
    rst_n = 1'b1;
    #1;
    check("post_rst_cmd_ready", 64'(cmdReady), 64'(1));

    // 1: single op, SETTLE=1
    rspReady = 1'b1;
    sendCmd(32'd5, 32'd7, 4'd0, 1'b0);
    check("t1_alu_a", 64'(aluA), 64'(5));
    check("t1_alu_b", 64'(aluB), 64'(7));
    check("t1_busy", 64'(busy), 64'(1));
    check("t1_cmd_ready_exec", 64'(cmdReady), 64'(0));
    check("t1_rsp_valid_early", 64'(rspValid), 64'(0));
    tick();
    check("t1_busy_done", 64'(busy), 64'(0));
    check("t1_rsp_valid", 64'(rspValid), 64'(1));
    check("t1_rsp_data", 64'(rspData), 64'(12));
    check("t1_rsp_op", 64'(rspOp), 64'(0));
    tick();
    check("t1_rsp_drained", 64'(rspValid), 64'(0));
    check("t1_alu_a_hold", 64'(aluA), 64'(5));

    // 3: SETTLE=3 instance, wrap-around sum
    c3Valid = 1'b1;
    c3A = 32'hFFFF_FFFF;
    c3B = 32'd1;
    c3Op = 4'd3;
    check("t3_cmd_ready", 64'(c3Ready), 64'(1));
    tick();
    c3Valid = 1'b0;
    c3A = '0;
    c3B = '0;
    for (int i = 0; i < 3; i++) begin
      check("t3_busy", 64'(busy3), 64'(1));
      check("t3_alu_a_stable", 64'(alu3A), 64'(32'hFFFF_FFFF));
      check("t3_alu_b_stable", 64'(alu3B), 64'(1));
      check("t3_no_rsp_yet", 64'(rsp3Valid), 64'(0));
      tick();
    end
    check("t3_rsp_valid", 64'(rsp3Valid), 64'(1));
    check("t3_rsp_data", 64'(rsp3Data), 64'(0));
    check("t3_rsp_op", 64'(rsp3Op), 64'(3));
    check("t3_busy_done", 64'(busy3), 64'(0));
    tick();
    check("t3_rsp_drained", 64'(rsp3Valid), 64'(0));

    // 2: fill the FIFO with rsp_ready low, then drain
    rspReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sendCmd(DATA_W'($urandom_range(0, 32'hFFFF)), DATA_W'($urandom_range(0, 32'hFFFF)),
              OP_W'(i + 1), 1'b0);
    end
    tick();
    check("t2_full_cmd_ready", 64'(cmdReady), 64'(0));
    check("t2_full_rsp_valid", 64'(rspValid), 64'(1));
    cmdValid = 1'b1;
    cmdA = DATA_W'($urandom_range(0, 1000));
    cmdB = DATA_W'($urandom_range(0, 1000));
    cmdOp = 4'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_blocked_busy", 64'(busy), 64'(0));
      check("t2_blocked_ready", 64'(cmdReady), 64'(0));
    end
    rspReady = 1'b1;
    tick();
    check("t2_ready_after_pop", 64'(cmdReady), 64'(1));
    tick();
    cmdValid = 1'b0;
    check("t2_fifth_accepted", 64'(busy), 64'(1));
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      tick();
      guard++;
    end
    check("t2_drain_done", 64'(exp_q.size()), 64'(0));
    check("t2_rsp_empty", 64'(rspValid), 64'(0));

    // 4: pop and push on the same edge
    rspReady = 1'b0;
    sendCmd(32'd100, 32'd23, 4'd4, 1'b0);
    tick();
    sumB = 32'd1000 + 32'd234;
    sendCmd(32'd1000, 32'd234, 4'd5, 1'b0);
    rspReady = 1'b1;
    check("t4_pre_rsp_valid", 64'(rspValid), 64'(1));
    check("t4_pre_busy", 64'(busy), 64'(1));
    tick();
    check("t4_count_kept", 64'(rspValid), 64'(1));
    check("t4_new_head_data", 64'(rspData), 64'(sumB));
    check("t4_new_head_op", 64'(rspOp), 64'(5));
    tick();
    check("t4_drained", 64'(rspValid), 64'(0));

`ifdef ALU_DRV_CHAIN_EN
    // 6: result forwarding
    sendCmd(32'd3, 32'd4, 4'd1, 1'b0);
    tick();
    tick();
    sendCmd(32'd99, 32'd10, 4'd2, 1'b1);
    check("t6_chained_alu_a", 64'(aluA), 64'(7));
    tick();
    check("t6_chained_rsp", 64'(rspData), 64'(17));
    tick();
    check("t6_drained", 64'(exp_q.size()), 64'(0));
`endif

    // 5: reset while an op is in flight and two responses are buffered
    rspReady = 1'b0;
    sendCmd(32'd11, 32'd22, 4'd6, 1'b0);
    tick();
    sendCmd(32'd33, 32'd44, 4'd7, 1'b0);
    tick();
    sendCmd(32'd55, 32'd66, 4'd8, 1'b0);
    check("t5_pre_busy", 64'(busy), 64'(1));
    check("t5_pre_rsp_valid", 64'(rspValid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_rsp_valid", 64'(rspValid), 64'(0));
    check("t5_rst_busy", 64'(busy), 64'(0));
    check("t5_rst_alu_a", 64'(aluA), 64'(0));
    check("t5_rst_alu_b", 64'(aluB), 64'(0));
    check("t5_rst_alu_op", 64'(aluOp), 64'(0));
    check("t5_rst_cmd_ready", 64'(cmdReady), 64'(0));
    exp_q.delete();
    mdlLast = '0;
    tick();
    tick();
    rst_n = 1'b1;
    rspReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_nothing_after_rst", 64'(rspValid), 64'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
